// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arb_pkg
//  Brief    : Shared types and helpers for the shared-register round-robin
//             write arbiter (state encoding, width helpers, hold counter width).
//  Revision : 1.0  initial release
// ============================================================================
package arb_pkg;

    // Arbiter ownership state: nobody owns the register, or one requester does
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_t;

    // Width of the consecutive-locked-write counter
    localparam int HOLD_W = 8;

    // Ceiling log2 for positive n (clog2(1) = 0)
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Owner index width; never narrower than one bit so NREQ=1 still has a port
    function automatic int owner_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Brief    : Combinational cyclic priority picker. Returns the first set bit
//             of req searching start, start+1, ..., NREQ-1, 0, ..., start-1.
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ    = 4,
    parameter int OWNER_W = 2
) (
    input  logic [NREQ-1:0]    req,
    input  logic [OWNER_W-1:0] start,
    output logic               any,
    output logic [OWNER_W-1:0] idx
);

    // Scan from the farthest candidate back to start so the nearest hit wins
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(start) + k) % NREQ]) begin
                any = 1'b1;
                idx = OWNER_W'((int'(start) + k) % NREQ);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/shared_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : shared_reg_arbiter
//  Brief    : Round-robin write arbiter for one shared WIDTH-bit register.
//             The winning requester's data slice is loaded into Q and
//             acknowledged; a requester holding Lock keeps ownership for
//             back-to-back writes. A released owner is searched last.
//  Config   : ARB_TIMEOUT_EN - when defined, an owner that has made MAX_HOLD
//             consecutive writes is forced to release if anyone else waits.
//  Revision : 1.0  initial release
// ============================================================================
module shared_reg_arbiter
    import arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 15
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [NREQ-1:0]            Req,
    input  logic [NREQ-1:0]            Lock,
    input  logic [NREQ*WIDTH-1:0]      Data,
    output logic [NREQ-1:0]            Gnt,
    output logic [NREQ-1:0]            Ack,
    output logic [owner_w(NREQ)-1:0]   Owner,
    output logic [WIDTH-1:0]           Q
);

    localparam int OWNER_W = owner_w(NREQ);

    // Reject unsupported configurations at elaboration time
    if (NREQ < 1 || NREQ > 8 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_params
        $error("shared_reg_arbiter: NREQ must be 1..8 and MAX_HOLD 1..255");
    end

    arb_state_t            r_state, w_state_nxt;
    logic [OWNER_W-1:0]    r_ptr, w_ptr_nxt;
    logic [OWNER_W-1:0]    r_owner, w_owner_nxt;
    logic [NREQ-1:0]       r_gnt, w_gnt_nxt;
    logic [NREQ-1:0]       r_ack, w_ack_nxt;
    logic [WIDTH-1:0]      r_q, w_q_nxt;

    logic [OWNER_W-1:0]    w_after_owner;
    logic [OWNER_W-1:0]    w_start;
    logic                  w_any;
    logic [OWNER_W-1:0]    w_idx;
    logic                  w_forced;
    logic                  w_keep;

`ifdef ARB_TIMEOUT_EN
    logic [HOLD_W-1:0]     r_hold_cnt, w_hold_nxt;
`endif

    // Position just after the current owner, wrapping at NREQ
    assign w_after_owner = (r_owner == OWNER_W'(NREQ - 1)) ? '0 : r_owner + 1'b1;

    // Idle searches from the saved pointer; a releasing owner searches from its successor
    assign w_start = (r_state == ST_OWN) ? w_after_owner : r_ptr;

`ifdef ARB_TIMEOUT_EN
    // Owner has used its quota and somebody else is waiting
    assign w_forced = (r_hold_cnt == HOLD_W'(MAX_HOLD)) && (|(Req & ~r_gnt));
`else
    assign w_forced = 1'b0;
`endif

    // Current owner continues with another locked write
    assign w_keep = Req[r_owner] & Lock[r_owner] & ~w_forced;

    rr_pick #(
        .NREQ    (NREQ),
        .OWNER_W (OWNER_W)
    ) u_pick (
        .req   (Req),
        .start (w_start),
        .any   (w_any),
        .idx   (w_idx)
    );

    // Next-state and next-output decode: locked write, re-pick on release, or idle
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_gnt_nxt   = r_gnt;
        w_ack_nxt   = '0;
        w_q_nxt     = r_q;
`ifdef ARB_TIMEOUT_EN
        w_hold_nxt  = r_hold_cnt;
`endif
        if (r_state == ST_OWN && w_keep) begin
            w_q_nxt   = Data[int'(r_owner)*WIDTH +: WIDTH];
            w_ack_nxt = r_gnt;
`ifdef ARB_TIMEOUT_EN
            w_hold_nxt = (r_hold_cnt >= HOLD_W'(MAX_HOLD)) ? HOLD_W'(MAX_HOLD)
                                                            : r_hold_cnt + 1'b1;
`endif
        end else begin
            if (r_state == ST_OWN) begin
                w_ptr_nxt = w_after_owner;
            end
            if (w_any) begin
                w_state_nxt = ST_OWN;
                w_owner_nxt = w_idx;
                w_gnt_nxt   = NREQ'(1) << w_idx;
                w_ack_nxt   = NREQ'(1) << w_idx;
                w_q_nxt     = Data[int'(w_idx)*WIDTH +: WIDTH];
`ifdef ARB_TIMEOUT_EN
                w_hold_nxt  = HOLD_W'(1);
`endif
            end else begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
`ifdef ARB_TIMEOUT_EN
                w_hold_nxt  = '0;
`endif
            end
        end
    end

    // State, pointer, shared register and grant/ack/owner registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_q     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ack   <= w_ack_nxt;
            r_q     <= w_q_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Consecutive-write counter for the current owner
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_hold_cnt <= '0;
        end else begin
            r_hold_cnt <= w_hold_nxt;
        end
    end
`endif

    assign Gnt   = r_gnt;
    assign Ack   = r_ack;
    assign Owner = r_owner;
    assign Q     = r_q;

endmodule
`default_nettype wire
